// File: rtl/piso_stream_tx.sv
// piso_stream_tx
// Parallel-in serial-out transmitter. Accepts WIDTH-bit words over a
// valid/ready handshake and shifts each one out one bit per clock as a
// framed serial stream, optionally followed by an even-parity bit.
// A one-word holding buffer lets the next word be handed over while the
// current frame is still shifting, so frames can stream back-to-back.
//
// Parameters:
//   WIDTH      data bits per word (>= 2)
//   LSB_FIRST  1 = bit 0 leaves first, 0 = bit WIDTH-1 leaves first
//   PARITY     1 = append an even-parity bit after the data bits
//
// Ports:
//   clk      rising-edge clock
//   clear_n  asynchronous active-low reset
//   p_in     parallel word from upstream
//   p_valid  p_in holds a word to transfer
//   p_ready  a word can be accepted this cycle (holding buffer empty)
//   s_out    serial bit
//   s_valid  s_out carries a frame bit this cycle
//   s_start  first bit of a frame
//   done     last bit of a frame
//   busy     a frame is shifting or the holding buffer is full
module piso_stream_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY    = 1'b0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [WIDTH-1:0] p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_start,
  output logic             done,
  output logic             busy
);

  localparam int F  = WIDTH + int'(PARITY);
  localparam int CW = $clog2(F + 1);
  localparam logic [CW-1:0] LAST = CW'(F - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [F-2:0]     shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hold_word, hold_word_nxt;
  logic             hold_full, hold_full_nxt;
  logic             s_out_nxt, s_valid_nxt, s_start_nxt, done_nxt, busy_nxt;
  logic             transfer;
  logic             do_load;
  logic [F-1:0]     load_frame;
  logic [F-1:0]     frame_in, frame_hold;

  // Reorders a word into transmit order: bit 0 of the result is the first
  // bit on the line, and the parity bit (if any) sits at the top.
  function automatic logic [F-1:0] build_frame(input logic [WIDTH-1:0] word);
    logic [F-1:0] f;
    f = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f[i] = LSB_FIRST ? word[i] : word[WIDTH-1-i];
    end
    if (PARITY) begin
      f[F-1] = ^word;
    end
    return f;
  endfunction

  // p_ready depends only on the registered flag so upstream never sees a
  // combinational path back from its own p_valid.
  assign p_ready    = !hold_full;
  assign transfer   = p_valid && p_ready;
  assign frame_in   = build_frame(p_in);
  assign frame_hold = build_frame(hold_word);

  // Next-state logic. The holding register only ever fills while a frame
  // is in progress and not on its last bit; on the last bit the shifter is
  // reloaded from the holding register first, else directly from p_in,
  // which is what keeps s_valid continuously high between frames.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    cnt_nxt       = cnt;
    hold_word_nxt = hold_word;
    hold_full_nxt = hold_full;
    s_out_nxt     = s_out;
    s_valid_nxt   = s_valid;
    s_start_nxt   = 1'b0;
    do_load       = 1'b0;
    load_frame    = frame_in;

    case (state)
      IDLE: begin
        if (transfer) begin
          do_load    = 1'b1;
          load_frame = frame_in;
        end else begin
          s_valid_nxt = 1'b0;
          s_out_nxt   = 1'b0;
          cnt_nxt     = '0;
        end
      end

      SHIFT: begin
        if (cnt == LAST) begin
          if (hold_full) begin
            do_load       = 1'b1;
            load_frame    = frame_hold;
            hold_full_nxt = 1'b0;
          end else if (transfer) begin
            do_load    = 1'b1;
            load_frame = frame_in;
          end else begin
            state_nxt   = IDLE;
            s_valid_nxt = 1'b0;
            s_out_nxt   = 1'b0;
            cnt_nxt     = '0;
            shreg_nxt   = '0;
          end
        end else begin
          cnt_nxt   = cnt + CW'(1);
          s_out_nxt = shreg[0];
          shreg_nxt = shreg >> 1;
          if (transfer) begin
            hold_word_nxt = p_in;
            hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A load presents frame bit 0 right away and parks the rest.
    if (do_load) begin
      state_nxt   = SHIFT;
      s_out_nxt   = load_frame[0];
      shreg_nxt   = load_frame[F-1:1];
      cnt_nxt     = '0;
      s_valid_nxt = 1'b1;
      s_start_nxt = 1'b1;
    end

    done_nxt = s_valid_nxt && (cnt_nxt == LAST);
    busy_nxt = (state_nxt == SHIFT) || hold_full_nxt;
  end

  // State and registered outputs; reset abandons any frame and discards
  // the holding word.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      hold_word <= '0;
      hold_full <= 1'b0;
      s_out     <= 1'b0;
      s_valid   <= 1'b0;
      s_start   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      hold_word <= hold_word_nxt;
      hold_full <= hold_full_nxt;
      s_out     <= s_out_nxt;
      s_valid   <= s_valid_nxt;
      s_start   <= s_start_nxt;
      done      <= done_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_piso_stream_tx.sv
// tb_piso_stream_tx
// Drives two instances of piso_stream_tx: dut_a with the defaults
// (LSB first, no parity) and dut_b MSB first with even parity. Each one is
// compared every cycle against a frame-level reference model built from
// a word queue and a bit position within the current frame.
module tb_piso_stream_tx;

  logic       clk;
  logic       clear_n;
  logic [3:0] p_in    [2];
  logic       p_valid [2];
  logic       p_ready [2];
  logic       s_out   [2];
  logic       s_valid [2];
  logic       s_start [2];
  logic       done    [2];
  logic       busy    [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, one slot per DUT
  bit         lsb_m   [2] = '{1'b1, 1'b0};
  int         par_m   [2] = '{0, 1};
  int         pos     [2];
  logic [3:0] cur_w   [2];
  logic [3:0] hold_w  [2];
  bit         hold_v  [2];
  bit         st      [2];
  bit         tr      [2];

  logic [3:0] src_a [$];
  logic [3:0] src_b [$];
  bit         rnd_mode;

  piso_stream_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .PARITY(1'b0)) dut_a (
    .clk(clk), .clear_n(clear_n), .p_in(p_in[0]), .p_valid(p_valid[0]),
    .p_ready(p_ready[0]), .s_out(s_out[0]), .s_valid(s_valid[0]),
    .s_start(s_start[0]), .done(done[0]), .busy(busy[0]));

  piso_stream_tx #(.WIDTH(4), .LSB_FIRST(1'b0), .PARITY(1'b1)) dut_b (
    .clk(clk), .clear_n(clear_n), .p_in(p_in[1]), .p_valid(p_valid[1]),
    .p_ready(p_ready[1]), .s_out(s_out[1]), .s_valid(s_valid[1]),
    .s_start(s_start[1]), .done(done[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frame_len(input int d);
    return 4 + par_m[d];
  endfunction

  // Bit idx of the frame for word w: data bits in the configured order,
  // then the even-parity bit (ones count modulo 2).
  function automatic logic frame_bit(input int d, input logic [3:0] w, input int idx);
    if (idx < 4) return lsb_m[d] ? w[idx] : w[3-idx];
    return logic'($countones(w) % 2);
  endfunction

  task automatic modelStep(input int d);
    if (!clear_n) begin
      pos[d] = -1; hold_v[d] = 0; st[d] = 0; tr[d] = 0;
      return;
    end
    tr[d] = p_valid[d] && !hold_v[d];
    if (tr[d]) begin
      hold_w[d] = p_in[d];
      hold_v[d] = 1;
    end
    st[d] = 0;
    if (pos[d] >= 0 && pos[d] < frame_len(d) - 1) begin
      pos[d]++;
    end else if (hold_v[d]) begin
      cur_w[d] = hold_w[d]; hold_v[d] = 0; pos[d] = 0; st[d] = 1;
    end else begin
      pos[d] = -1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < 2; d++) begin
      bit v;
      v = (pos[d] >= 0);
      checkOutput($sformatf("d%0d_s_valid", d), s_valid[d], v);
      checkOutput($sformatf("d%0d_s_out", d), s_out[d], v ? frame_bit(d, cur_w[d], pos[d]) : 1'b0);
      checkOutput($sformatf("d%0d_s_start", d), s_start[d], v && st[d]);
      checkOutput($sformatf("d%0d_done", d), done[d], v && (pos[d] == frame_len(d) - 1));
      checkOutput($sformatf("d%0d_busy", d), busy[d], v || hold_v[d]);
      checkOutput($sformatf("d%0d_p_ready", d), p_ready[d], !hold_v[d]);
    end
  endtask

  // Drive inputs for the coming edge: from the word queues, or random.
  task automatic applyStimulus();
    if (rnd_mode) begin
      for (int d = 0; d < 2; d++) begin
        p_valid[d] = ($urandom_range(0, 3) != 0);
        p_in[d]    = 4'($urandom_range(0, 15));
      end
    end else begin
      p_valid[0] = (src_a.size() > 0);
      p_in[0]    = (src_a.size() > 0) ? src_a[0] : 4'($urandom_range(0, 15));
      p_valid[1] = (src_b.size() > 0);
      p_in[1]    = (src_b.size() > 0) ? src_b[0] : 4'($urandom_range(0, 15));
    end
  endtask

  task automatic tick();
    applyStimulus();
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    #1;
    checkAll();
    if (!rnd_mode) begin
      if (tr[0] && src_a.size() > 0) void'(src_a.pop_front());
      if (tr[1] && src_b.size() > 0) void'(src_b.pop_front());
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit found;
    rnd_mode = 0;
    clear_n  = 1'b1;
    for (int d = 0; d < 2; d++) begin
      p_valid[d] = 1'b0; p_in[d] = 4'h0; pos[d] = -1;
      hold_v[d] = 0; st[d] = 0; tr[d] = 0; cur_w[d] = 4'h0; hold_w[d] = 4'h0;
    end

    // Reset takes effect without a clock
    #2 clear_n = 1'b0;
    #1;
    modelStep(0); modelStep(1);
    checkAll();
    runCycles(2);
    clear_n = 1'b1;

    // Single words: 1001 on dut_a, 1011 then 1010 on dut_b (parity 1, 0)
    src_a.push_back(4'b1001);
    src_b.push_back(4'b1011);
    src_b.push_back(4'b1010);
    runCycles(14);

    // Back-to-back streaming of three words with valid held high
    src_a.push_back(4'b1010); src_a.push_back(4'b1011); src_a.push_back(4'b1110);
    src_b.push_back(4'b1010); src_b.push_back(4'b1011); src_b.push_back(4'b1110);
    runCycles(20);

    // Last-bit transfer: offer 1111 exactly during the done cycle
    src_a.push_back(4'b1001);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (pos[0] == frame_len(0) - 1) found = 1;
    end
    checkOutput("lastbit_done_seen", done[0], 1'b1);
    src_a.push_back(4'b1111);
    tick();
    checkOutput("lastbit_no_gap_start", s_start[0], 1'b1);
    checkOutput("lastbit_no_gap_valid", s_valid[0], 1'b1);
    runCycles(6);

    // Stall: no valid for 10 cycles while p_in wanders
    runCycles(10);

    // Mid-frame reset after two bits of 1001
    src_a.push_back(4'b1001);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (pos[0] == 1) found = 1;
    end
    checkOutput("reset_mid_frame_valid_before", s_valid[0], 1'b1);
    #2 clear_n = 1'b0;
    #1;
    modelStep(0); modelStep(1);
    checkAll();
    checkOutput("reset_async_s_valid", s_valid[0], 1'b0);
    checkOutput("reset_async_p_ready", p_ready[0], 1'b1);
    runCycles(2);
    clear_n = 1'b1;
    runCycles(8);

    // Randomised traffic on both instances
    rnd_mode = 1;
    runCycles(400);
    rnd_mode = 0;
    runCycles(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_stream_tx.md
# piso_stream_tx

Parallel-in serial-out transmitter that consumes the 4-bit words produced by the parallel register stage and shifts them out one bit per clock as framed serial bits with an optional even-parity bit. A one-word holding buffer lets the upstream stage hand over the next word while the current frame is still shifting, so consecutive frames stream back-to-back with no idle cycle. It sits directly downstream of the PIPO register stage and drives the serial output / LED lane.

## Interface
- WIDTH, 4, data bits per word (≥2)
- LSB_FIRST, 1, 1 = bit 0 shifted first; 0 = bit WIDTH-1 first
- PARITY, 0, 1 = append one even-parity bit after the data bits; 0 = no parity bit

- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous, active-low reset
- p_in  input  WIDTH  parallel word from upstream
- p_valid  input  1  p_in holds a word to transfer
- p_ready  output  1  block can accept a word this cycle
- s_out  output  1  serial bit
- s_valid  output  1  s_out carries a frame bit this cycle
- s_start  output  1  high on the first bit of each frame
- done  output  1  high on the last bit of each frame
- busy  output  1  a frame is shifting or the holding buffer is full

## Operation
- Frame length F = WIDTH + PARITY bits. Parity bit = XOR of all WIDTH data bits (even parity).
- Storage: shift register + bit counter (clog2(F+1) bits), holding register + hold_full flag.
- States: IDLE (shifter empty), SHIFT (frame in progress).
- Transfer occurs on a rising edge with p_valid && p_ready. p_ready = !hold_full (combinational from the registered flag only; no dependency on p_valid).
- IDLE + transfer: word loads straight into the shifter, go to SHIFT, counter = 0.
- SHIFT + transfer (not last bit): word goes into the holding register, hold_full = 1.
- SHIFT, last bit (counter = F-1):
  - hold_full = 1: holding word moves to shifter, hold_full = 0, stay in SHIFT.
  - hold_full = 0 and transfer this edge: incoming word loads straight into the shifter, stay in SHIFT.
  - otherwise: go to IDLE.
- Direct load and hold load never occur on the same edge (p_ready = 0 whenever hold_full = 1).
- p_in sampled only on the transfer edge; changes at other times have no effect.
- busy = (state == SHIFT) || hold_full.

## Timing
- Reset (clear_n = 0, takes effect immediately, no clock required): s_out = 0, s_valid = 0, s_start = 0, done = 0, busy = 0, p_ready = 1, state IDLE, hold_full = 0, counter = 0. A frame in progress is abandoned; the holding word is discarded.
- All outputs except p_ready are registered.
- Latency: transfer at edge k from IDLE -> s_valid = 1, s_start = 1, first bit on s_out in cycle k+1 (after edge k). Bit i of the frame is presented in cycle k+1+i; done = 1 in cycle k+F.
- Back-to-back: with a word in the holding register, or a transfer on the last-bit edge, the next frame's first bit (s_start = 1) follows the previous done cycle with no gap; s_valid stays high.
- Throughput: one word per F cycles sustained.
- IDLE: s_valid = 0, s_out = 0, s_start = 0, done = 0.
- F = 1 is not supported (WIDTH ≥ 2).

## Test plan
- Reset: hold clear_n = 0 mid-frame (after 2 bits of 4'b1001) -> s_valid, s_out, busy, done drop to 0 immediately, p_ready = 1; after release, no residual bits are emitted.
- Single word, defaults: p_in = 4'b1001 transferred at edge k -> s_out = 1,0,0,1 in cycles k+1..k+4, s_start only in k+1, done only in k+4, IDLE in k+5.
- MSB-first with parity (LSB_FIRST = 0, PARITY = 1): p_in = 4'b1011 -> s_out = 1,0,1,1,1 (parity = 1), done on the 5th bit; p_in = 4'b1010 -> parity bit 0.
- Back-to-back: present 4'b1010, 4'b1011, 4'b1110 with p_valid held high -> second word held (p_ready = 0 until the first frame ends), 12 contiguous bits 0,1,0,1, 1,1,0,1, 0,1,1,1, s_valid never drops, s_start on bits 1, 5, 9.
- Last-bit transfer: hold buffer empty, p_valid rises exactly on the done cycle with 4'b1111 -> next frame starts the following cycle with no gap.
- Stall: p_valid = 0 for 10 cycles after one frame -> s_valid = 0, busy = 0, p_ready = 1 throughout; p_in toggling with p_valid = 0 produces no output.
